// File: rtl/ntt_butt_unit_pkg.sv
// Shared types and helpers for the multi-lane NTT butterfly.
// Contents: butt_mode_e (per-transaction mode), to_mode (raw mode code to
// enum, reserved code maps to bypass), BUTT_LAT (pipeline latency in cycles).
// Configuration macro: BUTT_FULL_REDUCE_EN adds one stage for full [0,p) reduction.
package ntt_butt_unit_pkg;

   typedef enum logic [1:0] {
      BM_FWD = 2'd0,
      BM_INV = 2'd1,
      BM_BYP = 2'd2
   } butt_mode_e;

   // Latency from input handshake to out_valid, in cycles of pipeline advance.
   function automatic int unsigned BUTT_LAT(input int unsigned mult_cycles);
`ifdef BUTT_FULL_REDUCE_EN
      return 2 * mult_cycles + 4;
`else
      return 2 * mult_cycles + 3;
`endif
   endfunction

   // Reserved code 3 behaves as bypass.
   function automatic butt_mode_e to_mode(input logic [1:0] m);
      case (m)
         2'd0:    return BM_FWD;
         2'd1:    return BM_INV;
         default: return BM_BYP;
      endcase
   endfunction

endpackage

// File: rtl/Mult.sv
// Pipelined W x W -> 2W unsigned multiplier with a stage enable.
// Ports: clk, en (all internal stages hold when low), x, y operands, z product
// (valid CYCLES enabled cycles after the operands were presented).
module Mult #(
   parameter int unsigned W      = 64,
   parameter int unsigned CYCLES = 3
) (
   input  logic             clk,
   input  logic             en,
   input  logic [W-1:0]     x,
   input  logic [W-1:0]     y,
   output logic [2*W-1:0]   z
);
   localparam int unsigned PW = 2 * W;

   logic [PW-1:0] pipe [CYCLES];

   always_ff @(posedge clk) begin
      if (en) begin
         pipe[0] <= PW'(x) * PW'(y);
         for (int unsigned i = 1; i < CYCLES; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign z = pipe[CYCLES-1];

endmodule

// File: rtl/ntt_butt_lane.sv
// One lane of the NTT butterfly datapath (forward CT / inverse GS / bypass)
// using Shoup multiplication with lazy [0,2p) reduction.
// Ports: clk, rst, en (stage enable), out_load (output register update),
// mode_in/p_in with a, b, w, wq (stage-1 inputs), p_mul (p aligned to the
// q*p multiplier), mode_fin/p_fin (aligned to the post-add stage),
// mode_red/p_red (aligned to the full-reduce stage, only with
// BUTT_FULL_REDUCE_EN), a_out, b_out (registered results).
module ntt_butt_lane
   import ntt_butt_unit_pkg::*;
#(
   parameter int unsigned DW = 64,
   parameter int unsigned M  = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          out_load,
   input  butt_mode_e    mode_in,
   input  logic [DW-1:0] p_in,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] w,
   input  logic [DW-1:0] wq,
   input  logic [DW-1:0] p_mul,
   input  butt_mode_e    mode_fin,
   input  logic [DW-1:0] p_fin,
`ifdef BUTT_FULL_REDUCE_EN
   input  butt_mode_e    mode_red,
   input  logic [DW-1:0] p_red,
`endif
   output logic [DW-1:0] a_out,
   output logic [DW-1:0] b_out
);
   localparam int unsigned NC = 2 * M + 2;  // carry stages S1..S(2M+2)
   localparam int unsigned PW = 2 * DW;
   localparam int unsigned EW = DW + 1;

   logic [EW-1:0] two_p_in, sum_in, dif_in, s_red;
   logic [DW-1:0] c_d [NC];   // a (fwd/byp) or reduced a+b (inv)
   logic [DW-1:0] x_d [NC];   // multiplier operand, also bypass b
   logic [DW-1:0] xw_d [M];   // low half of x*W, waiting for q*p
   logic [DW-1:0] w1, wq1, q, r_q;
   logic [PW-1:0] xw, xwq, qp;
   logic [EW-1:0] two_p_f, fsum, fdif, fsum_r, fdif_r;
   logic [DW-1:0] fin_a, fin_b, res_a, res_b;

   // Stage-1 pre-add/sub for the inverse butterfly.
   always_comb begin
      two_p_in = EW'(p_in) << 1;
      sum_in   = EW'(a) + EW'(b);
      dif_in   = EW'(a) + two_p_in - EW'(b);
      s_red    = (sum_in >= two_p_in) ? sum_in - two_p_in : sum_in;
   end

   assign q = DW'(xwq >> DW);

   // Operand capture, carry shift and the Shoup r subtract.
   always_ff @(posedge clk) begin
      if (en) begin
         w1  <= w;
         wq1 <= wq;
         if (mode_in == BM_INV) begin
            x_d[0] <= DW'(dif_in);
            c_d[0] <= DW'(s_red);
         end else begin
            x_d[0] <= b;
            c_d[0] <= a;
         end
         for (int unsigned k = 1; k < NC; k++) begin
            x_d[k] <= x_d[k-1];
            c_d[k] <= c_d[k-1];
         end
         xw_d[0] <= DW'(xw);
         for (int unsigned k = 1; k < M; k++) xw_d[k] <= xw_d[k-1];
         // Only the low DW bits matter: r = (x*W - q*p) mod 2^DW.
         r_q <= xw_d[M-1] - DW'(qp);
      end
   end

   Mult #(.W(DW), .CYCLES(M)) u_mul_xw  (.clk(clk), .en(en), .x(x_d[0]), .y(w1),    .z(xw));
   Mult #(.W(DW), .CYCLES(M)) u_mul_xwq (.clk(clk), .en(en), .x(x_d[0]), .y(wq1),   .z(xwq));
   Mult #(.W(DW), .CYCLES(M)) u_mul_qp  (.clk(clk), .en(en), .x(q),      .y(p_mul), .z(qp));

   // Post-add/sub with lazy reduction, and per-mode result selection.
   always_comb begin
      two_p_f = EW'(p_fin) << 1;
      fsum    = EW'(c_d[NC-1]) + EW'(r_q);
      fdif    = EW'(c_d[NC-1]) + two_p_f - EW'(r_q);
      fsum_r  = (fsum >= two_p_f) ? fsum - two_p_f : fsum;
      fdif_r  = (fdif >= two_p_f) ? fdif - two_p_f : fdif;
      fin_a   = c_d[NC-1];
      fin_b   = x_d[NC-1];
      case (mode_fin)
         BM_FWD: begin
            fin_a = DW'(fsum_r);
            fin_b = DW'(fdif_r);
         end
         BM_INV:  fin_b = r_q;
         default: ;
      endcase
   end

`ifdef BUTT_FULL_REDUCE_EN
   logic [DW-1:0] mid_a, mid_b;

   always_ff @(posedge clk) begin
      if (en) begin
         mid_a <= fin_a;
         mid_b <= fin_b;
      end
   end

   // Fold [p,2p) down to [0,p); bypass data stays bit-exact.
   always_comb begin
      res_a = mid_a;
      res_b = mid_b;
      if (mode_red != BM_BYP) begin
         if (mid_a >= p_red) res_a = mid_a - p_red;
         if (mid_b >= p_red) res_b = mid_b - p_red;
      end
   end
`else
   assign res_a = fin_a;
   assign res_b = fin_b;
`endif

   // Output stage only updates when a valid transaction moves in.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_out <= '0;
         b_out <= '0;
      end else if (out_load) begin
         a_out <= res_a;
         b_out <= res_b;
      end
   end

endmodule

// File: rtl/ntt_butt_unit.sv
// Multi-lane NTT butterfly: forward CT, inverse GS or bypass per transaction,
// one fixed-latency pipeline with global backpressure.
// Ports: clk, rst (sync, active high), in_valid/in_ready, mode, p, a, b, w, wq
// (lane i at [i*DW +: DW]), a_out, b_out, out_valid/out_ready.
// Configuration macro: BUTT_FULL_REDUCE_EN (outputs in [0,p), one extra stage).
module ntt_butt_unit
   import ntt_butt_unit_pkg::*;
#(
   parameter int unsigned DW          = 64,
   parameter int unsigned LANES       = 2,
   parameter int unsigned MULT_CYCLES = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          mode,
   input  logic [DW-1:0]       p,
   input  logic [LANES*DW-1:0] a,
   input  logic [LANES*DW-1:0] b,
   input  logic [LANES*DW-1:0] w,
   input  logic [LANES*DW-1:0] wq,
   output logic [LANES*DW-1:0] a_out,
   output logic [LANES*DW-1:0] b_out,
   output logic                out_valid,
   input  logic                out_ready
);
   localparam int unsigned N  = BUTT_LAT(MULT_CYCLES);
   localparam int unsigned NS = N - 1;   // stages before the output register

   logic [N-1:0] v;
   butt_mode_e   mode_s [NS];
   logic [DW-1:0] p_s   [NS];
   butt_mode_e   mode_n;
   logic         en;

   assign mode_n    = to_mode(mode);
   assign out_valid = v[N-1];
   // The only bubble the pipeline can absorb is an empty output stage.
   assign en        = out_ready || !v[N-1];
   assign in_ready  = en;

   // Valid bits: reset wins over enable.
   always_ff @(posedge clk) begin
      if (rst)     v <= '0;
      else if (en) v <= {v[N-2:0], in_valid};
   end

   // Mode and modulus travel alongside the data.
   always_ff @(posedge clk) begin
      if (en) begin
         mode_s[0] <= mode_n;
         p_s[0]    <= p;
         for (int unsigned k = 1; k < NS; k++) begin
            mode_s[k] <= mode_s[k-1];
            p_s[k]    <= p_s[k-1];
         end
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      ntt_butt_lane #(.DW(DW), .M(MULT_CYCLES)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .out_load (en && v[N-2]),
         .mode_in  (mode_n),
         .p_in     (p),
         .a        (a[i*DW +: DW]),
         .b        (b[i*DW +: DW]),
         .w        (w[i*DW +: DW]),
         .wq       (wq[i*DW +: DW]),
         .p_mul    (p_s[MULT_CYCLES]),
         .mode_fin (mode_s[2*MULT_CYCLES+1]),
         .p_fin    (p_s[2*MULT_CYCLES+1]),
`ifdef BUTT_FULL_REDUCE_EN
         .mode_red (mode_s[2*MULT_CYCLES+2]),
         .p_red    (p_s[2*MULT_CYCLES+2]),
`endif
         .a_out    (a_out[i*DW +: DW]),
         .b_out    (b_out[i*DW +: DW])
      );
   end

endmodule

// File: tb/tb_ntt_butt_unit.sv
// Bench for ntt_butt_unit: DW=32, LANES=2, MULT_CYCLES=3. A spec-level
// butterfly model feeds a scoreboard; one negedge process checks every output
// beat, hold behaviour under backpressure, reset state and latency.
// Honours BUTT_FULL_REDUCE_EN.
module tb_ntt_butt_unit;
   localparam int unsigned DW = 32;
   localparam int unsigned LANES = 2;
   localparam int unsigned MC = 3;
`ifdef BUTT_FULL_REDUCE_EN
   localparam int unsigned LAT = 2 * MC + 4;
   localparam bit FULL = 1'b1;
`else
   localparam int unsigned LAT = 2 * MC + 3;
   localparam bit FULL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic out_ready = 1'b1;
   logic [1:0] mode = 2'd0;
   logic [31:0] p = 32'd97;
   logic [63:0] a = '0, b = '0, w = '0, wq = '0;
   logic in_ready, out_valid;
   logic [63:0] a_out, b_out;

   ntt_butt_unit #(.DW(DW), .LANES(LANES), .MULT_CYCLES(MC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .p(p), .a(a), .b(b), .w(w), .wq(wq),
      .a_out(a_out), .b_out(b_out), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a_m;
      logic [63:0] b_m;
      bit          lit;
      logic [31:0] a_lit;
      logic [31:0] b_lit;
      int unsigned h;
   } exp_t;

   exp_t sb[$];
   int unsigned n_vec = 0, n_bad = 0, n_push = 0, n_pop = 0, adv = 0;
   bit rst_seen = 1'b0, stall_prev = 1'b0;
   logic [63:0] prev_a = '0, prev_b = '0;
   bit lit_en = 1'b0;
   logic [31:0] lit_a = '0, lit_b = '0;
   logic [31:0] w0v = 32'd5, w1v = 32'd17;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // WQ = floor(W * 2^32 / p)
   function automatic logic [31:0] calc_wq(input logic [31:0] ww, input logic [31:0] pp);
      logic [63:0] num;
      num = {ww, 32'h0};
      return 32'(num / {32'h0, pp});
   endfunction

   function automatic logic [31:0] shoup(input logic [31:0] x, input logic [31:0] ww,
                                        input logic [31:0] wwq, input logic [31:0] pp);
      logic [63:0] q, r;
      q = ({32'h0, x} * {32'h0, wwq}) >> 32;
      r = {32'h0, x} * {32'h0, ww} - q * {32'h0, pp};
      return r[31:0];
   endfunction

   function automatic void bfly(input logic [1:0] m, input logic [31:0] pp,
                                input logic [31:0] aa, input logic [31:0] bb,
                                input logic [31:0] ww, input logic [31:0] wwq,
                                output logic [31:0] ao, output logic [31:0] bo);
      logic [63:0] p2, t, s;
      p2 = {31'h0, pp, 1'b0};
      ao = aa;
      bo = bb;
      if (m == 2'd0) begin
         t = {32'h0, shoup(bb, ww, wwq, pp)};
         s = {32'h0, aa} + t;
         if (s >= p2) s = s - p2;
         ao = s[31:0];
         s = {32'h0, aa} + p2 - t;
         if (s >= p2) s = s - p2;
         bo = s[31:0];
      end else if (m == 2'd1) begin
         s = {32'h0, aa} + {32'h0, bb};
         if (s >= p2) s = s - p2;
         ao = s[31:0];
         t = {32'h0, aa} + p2 - {32'h0, bb};
         bo = shoup(t[31:0], ww, wwq, pp);
      end
      if (FULL && m < 2'd2) begin
         if (ao >= pp) ao = ao - pp;
         if (bo >= pp) bo = bo - pp;
      end
   endfunction

   // Single compare process: reset state, hold under stall, output vs model.
   always @(negedge clk) begin
      exp_t e;
      logic [31:0] ao, bo;
      if (rst) begin
         sb.delete();
         rst_seen = 1'b1;
         stall_prev = 1'b0;
      end else begin
         if (rst_seen) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_a_out", a_out, 64'd0);
            chk("rst_b_out", b_out, 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            rst_seen = 1'b0;
         end
         if (stall_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_a", a_out, prev_a);
            chk("hold_b", b_out, prev_b);
         end
         if (out_valid && !out_ready) chk("stall_in_ready", 64'(in_ready), 64'd0);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               fail_now("stale_valid");
            end else begin
               e = sb.pop_front();
               n_pop++;
               chk("a_out", a_out, e.a_m);
               chk("b_out", b_out, e.b_m);
               chk("latency", 64'(adv - e.h), 64'(LAT));
               if (e.lit) begin
                  chk("lit_a", {32'h0, a_out[31:0]}, {32'h0, e.a_lit});
                  chk("lit_b", {32'h0, b_out[31:0]}, {32'h0, e.b_lit});
               end
            end
         end
         if (in_valid && in_ready) begin
            for (int i = 0; i < 2; i++) begin
               bfly(mode, p, a[i*32 +: 32], b[i*32 +: 32], w[i*32 +: 32], wq[i*32 +: 32], ao, bo);
               e.a_m[i*32 +: 32] = ao;
               e.b_m[i*32 +: 32] = bo;
            end
            e.lit = lit_en;
            e.a_lit = lit_a;
            e.b_lit = lit_b;
            e.h = adv;
            sb.push_back(e);
            n_push++;
         end
         stall_prev = out_valid && !out_ready;
         prev_a = a_out;
         prev_b = b_out;
         if (in_ready) adv++;
      end
   end

   task automatic send(input logic [1:0] m, input logic [31:0] pp,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input bit li, input logic [31:0] la, input logic [31:0] lb);
      bit hs;
      mode = m;
      p = pp;
      a = {a1, a0};
      b = {b1, b0};
      w = {w1v, w0v};
      wq = {calc_wq(w1v, pp), calc_wq(w0v, pp)};
      lit_en = li;
      lit_a = la;
      lit_b = lb;
      in_valid = 1'b1;
      hs = 1'b0;
      for (int k = 0; k < 200 && !hs; k++) begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      lit_en = 1'b0;
      if (!hs) fail_now("handshake_timeout");
   endtask

   task automatic send_rand(input logic [31:0] pp);
      send(2'($urandom_range(0, 3)), pp,
           $urandom_range(0, 2 * pp - 1), $urandom_range(0, 2 * pp - 1),
           $urandom_range(0, 2 * pp - 1), $urandom_range(0, 2 * pp - 1),
           1'b0, 32'd0, 32'd0);
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && sb.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      if (sb.size() != 0) fail_now("drain_timeout");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [31:0] ao, bo;
      // Pin the model against hand-computed values.
      chk("pin_wq", {32'h0, calc_wq(32'd5, 32'd97)}, 64'd221390066);
      bfly(2'd0, 32'd97, 32'd10, 32'd20, 32'd5, 32'd221390066, ao, bo);
      chk("pin_fwd", {ao, bo}, {32'd13, 32'd7});
      bfly(2'd1, 32'd97, 32'd10, 32'd20, 32'd5, 32'd221390066, ao, bo);
      chk("pin_inv", {ao, bo}, {32'd30, 32'd47});
      bfly(2'd0, 32'd97, 32'd150, 32'd0, 32'd5, 32'd221390066, ao, bo);
      chk("pin_fwd_lazy", {ao, bo}, FULL ? {32'd53, 32'd53} : {32'd150, 32'd150});

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed single transactions, p=97, W=5 / 17.
      send(2'd0, 32'd97, 32'd10, 32'd20, 32'd50, 32'd100, 1'b1, 32'd13, 32'd7);
      drain();
      send(2'd1, 32'd97, 32'd10, 32'd20, 32'd193, 32'd193, 1'b1, 32'd30, 32'd47);
      drain();
      if (FULL) send(2'd0, 32'd97, 32'd150, 32'd0, 32'd0, 32'd193, 1'b1, 32'd53, 32'd53);
      else      send(2'd0, 32'd97, 32'd150, 32'd0, 32'd0, 32'd193, 1'b1, 32'd150, 32'd150);
      drain();

      // Mixed-mode back-to-back stream, including reserved mode 3.
      send(2'd0, 32'd97, 32'd33, 32'd180, 32'd1, 32'd2, 1'b0, 32'd0, 32'd0);
      send(2'd2, 32'd97, 32'd7, 32'd9, 32'd150, 32'd160, 1'b1, 32'd7, 32'd9);
      send(2'd1, 32'd97, 32'd190, 32'd5, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      send(2'd3, 32'd97, 32'd1, 32'd2, 32'd3, 32'd4, 1'b1, 32'd1, 32'd2);
      drain();

      // Wide modulus burst with a 3-cycle out_ready stall mid-stream.
      w0v = 32'd123456789;
      w1v = 32'd987654321;
      n_push = 0;
      n_pop = 0;
      fork
         begin
            for (int i = 0; i < 16; i++) send_rand(32'd1073741789);
         end
         begin
            repeat (12) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("io_count", 64'(n_pop), 64'(n_push));

      // Reset with four transactions in flight.
      w0v = 32'd5;
      w1v = 32'd17;
      for (int i = 0; i < 4; i++) send_rand(32'd97);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (LAT + 3) @(posedge clk);
      #1;
      send(2'd0, 32'd97, 32'd10, 32'd20, 32'd5, 32'd6, 1'b1, 32'd13, 32'd7);
      drain();
      chk("final_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ntt_butt_unit.md
# ntt_butt_unit

Parametrised multi-lane NTT butterfly. It supersedes the single-mode inverse butterfly, and each transaction selects forward Cooley-Tukey, inverse Gentleman-Sande, or in-order bypass. The unit sits between the NTT coefficient-bank read mux and the write-back path. It uses Shoup modular multiplication with lazy [0,2p) reduction. A single fixed-latency pipeline serves every mode, with global backpressure, so bypassed and computed data never reorder.

## Interface
- `DW`, 64: coefficient width; modulus must satisfy p < 2^(DW-2).
- `LANES`, 2: independent butterflies per transaction, sharing one p.
- `MULT_CYCLES`, 3: pipeline depth of each DW×DW multiplier.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: transaction present.
- `in_ready` out 1: unit accepts the transaction this cycle.
- `mode` in 2: 0 = forward CT, 1 = inverse GS, 2 = bypass, 3 = reserved (treated as bypass).
- `p` in DW: modulus, captured per transaction.
- `a`, `b` in LANES*DW: operands, lane i at [i*DW +: DW], each in [0,2p).
- `w`, `wq` in LANES*DW: twiddle W<p and WQ = floor(W·2^DW/p) per lane.
- `a_out`, `b_out` out LANES*DW: results.
- `out_valid` out 1: results present.
- `out_ready` in 1: downstream accepts.

## Operation
- Shoup(x,W,WQ): q = (x·WQ)>>DW; r = (x·W − q·p) mod 2^DW; r lies in [0,2p) for x < 4p.
- Forward: t = Shoup(b); a' = a+t, minus 2p if ≥2p; b' = a−t+2p, minus 2p if ≥2p.
- Inverse: s = a+b, minus 2p if ≥2p; d = a−b+2p; a' = s; b' = Shoup(d).
- Bypass: a' = a, b' = b, bit-exact; the transaction traverses the full pipeline.
- Intermediate widths: pre-add and sub are DW+1 bits; products are 2DW; the final subtract keeps the low DW bits.
- Mode, p and per-lane data travel with their valid bit, so mixed-mode back-to-back streams are legal.
- Stages:
  - S1: pre-add/sub (inverse) or pass b (forward).
  - S2..S(M+1): x·W and x·WQ in parallel.
  - S(M+2)..S(2M+1): q·p.
  - S(2M+2): r subtract.
  - S(2M+3): post-add/sub (forward) and final conditional subtract.
  - M = MULT_CYCLES.

## Timing
- Latency LAT = 2·MULT_CYCLES+3 cycles of pipeline advance, from input handshake to output valid. LAT becomes +1 with the configuration macro.
- Pipeline enable en = out_ready || !out_valid. in_ready = en.
- With en low, every stage holds, including multiplier internals. a_out, b_out and out_valid stay stable. A bubble may be absorbed only at the output stage.
- Throughput is one transaction per cycle while out_ready=1.
- Reset: all stage valid bits clear. out_valid=0, a_out=b_out=0, in_ready=1 on the cycle after rst. Reset mid-flight drops every in-flight transaction.
- rst has priority over en.
- Inputs that violate [0,2p) or the p bound give undefined data. Valid timing is unaffected.

## Configuration
- `BUTT_FULL_REDUCE_EN`:
  - Defined: an extra stage subtracts p when a result is ≥p, so outputs lie in [0,p). LAT = 2·MULT_CYCLES+4. Bypass is still untouched.
  - Undefined: outputs are lazy in [0,2p).

## Structure
- FHE_ALU_PKG gains:
  - `butt_mode_e` (BM_FWD, BM_INV, BM_BYP).
  - `BUTT_LAT` as a function of MULT_CYCLES and the macro.
- Sub-module `ntt_butt_lane`: one lane's datapath with stage enable input; the top owns valid/mode/p shift, handshake and lane generation.
- Multipliers reuse the existing `Mult`, with an enable added.

## Test plan
Common setup: DW=32, p=97, W=5, WQ=221390066, LANES=2.
- Forward, a=10, b=20 → a'=13, b'=7, out_valid exactly LAT cycles after the handshake.
- Inverse, a=10, b=20 → a'=30, b'=47.
- Forward, a=150, b=0:
  - without macro → a'=150, b'=150;
  - with `BUTT_FULL_REDUCE_EN` → a'=53, b'=53.
- Stream FWD, BYP(a=7, b=9), INV back-to-back → outputs on consecutive cycles in input order; the bypass transaction emerges as 7, 9.
- out_ready low for 3 cycles during a streaming burst:
  - outputs held stable and in_ready=0;
  - no loss or duplication;
  - total outputs = inputs.
- Assert rst while 4 transactions are in flight → out_valid=0, outputs 0 next cycle, no stale valid ever emerges; a new transaction after reset completes in LAT.
